// File: rtl/wb_spi_mailbox.sv
// Request mailbox between the Wishbone slave and the SPI master: per-slot state,
// round-robin issue to SPI over valid/ready, and parked read responses.
module wb_spi_mailbox #(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [SLOT_W-1:0] req_slot,
  input  logic              req_rd,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  input  logic              host_rd_en,
  input  logic [SLOT_W-1:0] host_rd_slot,
  output logic              host_rd_stall,
  output logic              host_rd_ack,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              spi_cmd_valid,
  input  logic              spi_cmd_ready,
  output logic [SLOT_W-1:0] spi_cmd_slot,
  output logic              spi_cmd_rd,
  output logic [DATA_W-1:0] spi_cmd_data,
  input  logic              spi_rsp_valid,
  input  logic [SLOT_W-1:0] spi_rsp_slot,
  input  logic [DATA_W-1:0] spi_rsp_data,
  output logic              rsp_err,
  output logic [SLOT_W:0]   pending_cnt,
  output logic              full
);

  localparam int unsigned DEPTH = 2**SLOT_W;
  localparam int unsigned CNT_W = SLOT_W + 1;

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_ISSUED, ST_DONE} slot_st_e;

  slot_st_e          st_q   [DEPTH];
  slot_st_e          st_d   [DEPTH];
  logic [DEPTH-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              cmd_valid_q, cmd_valid_d;
  logic [SLOT_W-1:0] cmd_slot_q, cmd_slot_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [SLOT_W-1:0] last_grant_q, last_grant_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] hdata_q, hdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              full_q, full_d;

  logic              hs;
  logic              found;
  logic [SLOT_W-1:0] pick;
  logic [SLOT_W-1:0] base;
  logic [SLOT_W-1:0] idx;

  assign req_ready     = (st_q[req_slot] == ST_FREE);
  assign host_rd_stall = host_rd_en && (st_q[host_rd_slot] != ST_DONE);
  assign hs            = cmd_valid_q && spi_cmd_ready;

  assign spi_cmd_valid = cmd_valid_q;
  assign spi_cmd_slot  = cmd_slot_q;
  assign spi_cmd_rd    = cmd_rd_q;
  assign spi_cmd_data  = cmd_data_q;
  assign host_rd_ack   = ack_q;
  assign host_rd_data  = hdata_q;
  assign rsp_err       = err_q;
  assign pending_cnt   = pcnt_q;
  assign full          = full_q;

  // Slot transitions; every event keys on a distinct pre-edge state, so none collide.
  always_comb begin
    st_d   = st_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (req_valid && req_ready) begin
      st_d[req_slot]   = ST_PEND;
      rd_d[req_slot]   = req_rd;
      data_d[req_slot] = req_data;
    end
    if (hs) begin
      st_d[cmd_slot_q] = cmd_rd_q ? ST_ISSUED : ST_FREE;
    end
    if (spi_rsp_valid && (st_q[spi_rsp_slot] == ST_ISSUED)) begin
      st_d[spi_rsp_slot]   = ST_DONE;
      data_d[spi_rsp_slot] = spi_rsp_data;
    end
    if (host_rd_en && !host_rd_stall) begin
      st_d[host_rd_slot] = ST_FREE;
    end
  end

  // Round-robin search; the slot completing its handshake now is skipped.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    base  = hs ? (cmd_slot_q + SLOT_W'(1)) : (last_grant_q + SLOT_W'(1));
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = base + SLOT_W'(k);
      if (!found && (st_q[idx] == ST_PEND) && !(hs && (idx == cmd_slot_q))) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_slot_d   = cmd_slot_q;
    cmd_rd_d     = cmd_rd_q;
    cmd_data_d   = cmd_data_q;
    last_grant_d = last_grant_q;
    if (hs) begin
      last_grant_d = cmd_slot_q;
    end
    if (!cmd_valid_q || hs) begin
      cmd_valid_d = found;
      if (found) begin
        cmd_slot_d = pick;
        cmd_rd_d   = rd_q[pick];
        cmd_data_d = data_q[pick];
      end
    end
    ack_d   = host_rd_en && !host_rd_stall;
    hdata_d = ack_d ? data_q[host_rd_slot] : hdata_q;
    err_d   = spi_rsp_valid && (st_q[spi_rsp_slot] != ST_ISSUED);
    pcnt_d  = '0;
    full_d  = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (st_d[k] == ST_PEND) pcnt_d = pcnt_d + CNT_W'(1);
      if (st_d[k] == ST_FREE) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        st_q[k]   <= ST_FREE;
        data_q[k] <= '0;
      end
      rd_q         <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_slot_q   <= '0;
      cmd_rd_q     <= 1'b0;
      cmd_data_q   <= '0;
      last_grant_q <= SLOT_W'(DEPTH - 1);
      ack_q        <= 1'b0;
      hdata_q      <= '0;
      err_q        <= 1'b0;
      pcnt_q       <= '0;
      full_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      data_q       <= data_d;
      rd_q         <= rd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_slot_q   <= cmd_slot_d;
      cmd_rd_q     <= cmd_rd_d;
      cmd_data_q   <= cmd_data_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      hdata_q      <= hdata_d;
      err_q        <= err_d;
      pcnt_q       <= pcnt_d;
      full_q       <= full_d;
    end
  end

endmodule

// File: tb/tb_wb_spi_mailbox.sv
// Directed bench for wb_spi_mailbox: a per-cycle vector table for post/issue/collect,
// then hand sequences for arbitration order, fill, and asynchronous reset.
module tb_wb_spi_mailbox;

  logic        clk, rst;
  logic        req_valid, req_rd, req_ready;
  logic [3:0]  req_slot;
  logic [39:0] req_data;
  logic        host_rd_en, host_rd_stall, host_rd_ack;
  logic [3:0]  host_rd_slot;
  logic [39:0] host_rd_data;
  logic        spi_cmd_valid, spi_cmd_ready, spi_cmd_rd;
  logic [3:0]  spi_cmd_slot;
  logic [39:0] spi_cmd_data;
  logic        spi_rsp_valid;
  logic [3:0]  spi_rsp_slot;
  logic [39:0] spi_rsp_data;
  logic        rsp_err, full;
  logic [4:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  wb_spi_mailbox #(.DATA_W(40), .SLOT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_slot(req_slot), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .host_rd_en(host_rd_en), .host_rd_slot(host_rd_slot), .host_rd_stall(host_rd_stall),
    .host_rd_ack(host_rd_ack), .host_rd_data(host_rd_data),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd_ready(spi_cmd_ready), .spi_cmd_slot(spi_cmd_slot),
    .spi_cmd_rd(spi_cmd_rd), .spi_cmd_data(spi_cmd_data),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_slot(spi_rsp_slot), .spi_rsp_data(spi_rsp_data),
    .rsp_err(rsp_err), .pending_cnt(pending_cnt), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rv; logic [3:0] rs; logic rrd; logic [39:0] rdat;
    logic hen; logic [3:0] hs; logic crdy; logic pv; logic [3:0] ps; logic [39:0] pd;
    logic e_rdy; logic e_stall; logic e_ack; logic [39:0] e_hdata;
    logic e_cv; logic [3:0] e_cs; logic e_crd; logic [39:0] e_cd;
    logic e_err; logic [4:0] e_pc; logic e_full;
  } vec_t;

  localparam logic [39:0] Z  = 40'h00_0000_0000;
  localparam logic [39:0] W  = 40'h00_1234_5678;
  localparam logic [39:0] R  = 40'h0A_BCDE_F012;
  localparam logic [39:0] P5 = 40'h55_0000_0005;
  localparam logic [39:0] E  = 40'hFF_FFFF_FFFF;

  vec_t tv [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //           rv    rs     rrd   rdat hen   hs     crdy  pv    ps     pd  | rdy   stall ack   hdata cv    cs     crd   cd  err   pc     full
    tv[0]  = '{1'b0, 4'd0, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, Z, 1'b0, 4'd0, 1'b0, Z,  1'b0, 5'd0, 1'b0};
    tv[1]  = '{1'b1, 4'd3, 1'b0, W,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, Z, 1'b0, 4'd0, 1'b0, Z,  1'b0, 5'd0, 1'b0};
    tv[2]  = '{1'b0, 4'd3, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b0, 4'd0, 1'b0, Z,  1'b0, 5'd1, 1'b0};
    tv[3]  = '{1'b0, 4'd3, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b1, 4'd3, 1'b0, W,  1'b0, 5'd1, 1'b0};
    tv[4]  = tv[3];
    tv[5]  = tv[3];
    tv[6]  = '{1'b0, 4'd3, 1'b0, Z,  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b1, 4'd3, 1'b0, W,  1'b0, 5'd1, 1'b0};
    tv[7]  = '{1'b0, 4'd3, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, Z, 1'b0, 4'd3, 1'b0, W,  1'b0, 5'd0, 1'b0};
    tv[8]  = '{1'b1, 4'd5, 1'b1, P5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, Z, 1'b0, 4'd3, 1'b0, W,  1'b0, 5'd0, 1'b0};
    tv[9]  = '{1'b0, 4'd5, 1'b0, Z,  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b0, 4'd3, 1'b0, W,  1'b0, 5'd1, 1'b0};
    tv[10] = '{1'b0, 4'd5, 1'b0, Z,  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b1, 4'd5, 1'b1, P5, 1'b0, 5'd1, 1'b0};
    tv[11] = '{1'b0, 4'd5, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b1, 4'd5, R,   1'b0, 1'b0, 1'b0, Z, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[12] = '{1'b0, 4'd5, 1'b0, Z,  1'b1, 4'd5, 1'b0, 1'b0, 4'd0, Z,   1'b0, 1'b0, 1'b0, Z, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[13] = '{1'b0, 4'd5, 1'b0, Z,  1'b1, 4'd5, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b1, 1'b1, R, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[14] = '{1'b0, 4'd7, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, R, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[15] = '{1'b0, 4'd7, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b1, 4'd7, E,   1'b1, 1'b0, 1'b0, R, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[16] = '{1'b0, 4'd7, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, R, 1'b0, 4'd5, 1'b1, P5, 1'b1, 5'd0, 1'b0};
    tv[17] = '{1'b0, 4'd7, 1'b0, Z,  1'b1, 4'd7, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b1, 1'b0, R, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};
    tv[18] = '{1'b0, 4'd7, 1'b0, Z,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, Z,   1'b1, 1'b0, 1'b0, R, 1'b0, 4'd5, 1'b1, P5, 1'b0, 5'd0, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_slot = '0; req_rd = 1'b0; req_data = '0;
    host_rd_en = 1'b0; host_rd_slot = '0; spi_cmd_ready = 1'b0;
    spi_rsp_valid = 1'b0; spi_rsp_slot = '0; spi_rsp_data = '0;
    #12 rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      req_valid = tv[i].rv; req_slot = tv[i].rs; req_rd = tv[i].rrd; req_data = tv[i].rdat;
      host_rd_en = tv[i].hen; host_rd_slot = tv[i].hs; spi_cmd_ready = tv[i].crdy;
      spi_rsp_valid = tv[i].pv; spi_rsp_slot = tv[i].ps; spi_rsp_data = tv[i].pd;
      #1;
      chk($sformatf("v%0d.req_ready", i), 64'(req_ready), 64'(tv[i].e_rdy));
      chk($sformatf("v%0d.rd_stall", i), 64'(host_rd_stall), 64'(tv[i].e_stall));
      chk($sformatf("v%0d.rd_ack", i), 64'(host_rd_ack), 64'(tv[i].e_ack));
      chk($sformatf("v%0d.rd_data", i), 64'(host_rd_data), 64'(tv[i].e_hdata));
      chk($sformatf("v%0d.cmd_valid", i), 64'(spi_cmd_valid), 64'(tv[i].e_cv));
      chk($sformatf("v%0d.cmd_slot", i), 64'(spi_cmd_slot), 64'(tv[i].e_cs));
      chk($sformatf("v%0d.cmd_rd", i), 64'(spi_cmd_rd), 64'(tv[i].e_crd));
      chk($sformatf("v%0d.cmd_data", i), 64'(spi_cmd_data), 64'(tv[i].e_cd));
      chk($sformatf("v%0d.rsp_err", i), 64'(rsp_err), 64'(tv[i].e_err));
      chk($sformatf("v%0d.pending_cnt", i), 64'(pending_cnt), 64'(tv[i].e_pc));
      chk($sformatf("v%0d.full", i), 64'(full), 64'(tv[i].e_full));
      tick();
    end
    req_valid = 1'b0; host_rd_en = 1'b0; spi_rsp_valid = 1'b0;

    // Burst of posts with ready tied high: issue order 0, 1, 2 back-to-back.
    spi_cmd_ready = 1'b1; req_valid = 1'b1; req_rd = 1'b0;
    req_slot = 4'd0; req_data = 40'h11;
    #1 chk("rr.rdy0", 64'(req_ready), 64'd1); tick();
    req_slot = 4'd1; req_data = 40'h22;
    #1 chk("rr.c1.valid", 64'(spi_cmd_valid), 64'd0); tick();
    req_slot = 4'd2; req_data = 40'h33;
    #1 chk("rr.c2.valid", 64'(spi_cmd_valid), 64'd1);
    chk("rr.c2.slot", 64'(spi_cmd_slot), 64'd0);
    chk("rr.c2.data", 64'(spi_cmd_data), 64'h11); tick();
    req_valid = 1'b0;
    #1 chk("rr.c3.slot", 64'(spi_cmd_slot), 64'd1);
    chk("rr.c3.data", 64'(spi_cmd_data), 64'h22); tick();
    #1 chk("rr.c4.valid", 64'(spi_cmd_valid), 64'd1);
    chk("rr.c4.slot", 64'(spi_cmd_slot), 64'd2); tick();

    // Slot 8 held while 1 then 0 are posted: wrap-around picks 0 before 1.
    spi_cmd_ready = 1'b0; req_valid = 1'b1; req_slot = 4'd8; req_data = 40'h88;
    #1 chk("rr.c5.valid", 64'(spi_cmd_valid), 64'd0);
    chk("rr.c5.pcnt", 64'(pending_cnt), 64'd0); tick();
    req_slot = 4'd1; req_data = 40'h21;
    #1 tick();
    req_slot = 4'd0; req_data = 40'h20;
    #1 chk("wrap.hold.slot", 64'(spi_cmd_slot), 64'd8); tick();
    req_valid = 1'b0; spi_cmd_ready = 1'b1;
    #1 chk("wrap.hs.slot", 64'(spi_cmd_slot), 64'd8);
    chk("wrap.hs.pcnt", 64'(pending_cnt), 64'd3); tick();
    #1 chk("wrap.first.slot", 64'(spi_cmd_slot), 64'd0);
    chk("wrap.first.data", 64'(spi_cmd_data), 64'h20);
    chk("wrap.first.pcnt", 64'(pending_cnt), 64'd2); tick();
    #1 chk("wrap.second.slot", 64'(spi_cmd_slot), 64'd1);
    chk("wrap.second.valid", 64'(spi_cmd_valid), 64'd1); tick();
    spi_cmd_ready = 1'b0;
    #1 chk("wrap.idle.valid", 64'(spi_cmd_valid), 64'd0);
    chk("wrap.idle.pcnt", 64'(pending_cnt), 64'd0);

    // Fill every slot with writes while the SPI side is stalled.
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_slot = 4'(i); req_rd = 1'b0; req_data = 40'(i);
      #1 chk($sformatf("fill%0d.rdy", i), 64'(req_ready), 64'd1);
      chk($sformatf("fill%0d.full", i), 64'(full), 64'd0);
      tick();
    end
    req_valid = 1'b0;
    #1 chk("fill.full", 64'(full), 64'd1);
    chk("fill.pcnt", 64'(pending_cnt), 64'd16);
    chk("fill.cmd_slot", 64'(spi_cmd_slot), 64'd0);
    for (int s = 0; s < 16; s++) begin
      req_slot = 4'(s);
      #1 chk($sformatf("fill.ready%0d", s), 64'(req_ready), 64'd0);
    end
    spi_cmd_ready = 1'b1;
    #1 chk("fill.hs.full", 64'(full), 64'd1); tick();
    spi_cmd_ready = 1'b0; req_slot = 4'd0;
    #1 chk("drain.full", 64'(full), 64'd0);
    chk("drain.pcnt", 64'(pending_cnt), 64'd15);
    chk("drain.next_slot", 64'(spi_cmd_slot), 64'd1);
    chk("drain.rdy0", 64'(req_ready), 64'd1);

    // Reset clears everything, including the held command.
    rst = 1'b1;
    #1 chk("rst1.valid", 64'(spi_cmd_valid), 64'd0);
    chk("rst1.pcnt", 64'(pending_cnt), 64'd0);
    chk("rst1.full", 64'(full), 64'd0);
    #1 rst = 1'b0; tick();

    // Read to slot 4; a response in its handshake cycle is an error.
    req_valid = 1'b1; req_slot = 4'd4; req_rd = 1'b1; req_data = 40'h44;
    #1 tick();
    req_valid = 1'b0;
    #1 tick();
    #1 chk("r4.valid", 64'(spi_cmd_valid), 64'd1);
    chk("r4.slot", 64'(spi_cmd_slot), 64'd4);
    chk("r4.rd", 64'(spi_cmd_rd), 64'd1);
    spi_cmd_ready = 1'b1; spi_rsp_valid = 1'b1; spi_rsp_slot = 4'd4; spi_rsp_data = 40'h99;
    tick();
    spi_cmd_ready = 1'b0; spi_rsp_valid = 1'b0;
    req_valid = 1'b1; req_slot = 4'd6; req_rd = 1'b0; req_data = 40'h66;
    #1 chk("same_cycle.err", 64'(rsp_err), 64'd1);
    chk("same_cycle.valid", 64'(spi_cmd_valid), 64'd0);
    chk("same_cycle.pcnt", 64'(pending_cnt), 64'd0); tick();
    req_valid = 1'b0;
    #1 chk("err.once", 64'(rsp_err), 64'd0); tick();
    #1 chk("held6.valid", 64'(spi_cmd_valid), 64'd1);
    chk("held6.slot", 64'(spi_cmd_slot), 64'd6);

    // Asynchronous reset mid-cycle with slot 4 ISSUED and slot 6 held.
    #2 rst = 1'b1;
    #1 chk("rst2.valid", 64'(spi_cmd_valid), 64'd0);
    chk("rst2.slot", 64'(spi_cmd_slot), 64'd0);
    chk("rst2.data", 64'(spi_cmd_data), 64'd0);
    chk("rst2.pcnt", 64'(pending_cnt), 64'd0);
    rst = 1'b0;
    #1 tick();
    spi_rsp_valid = 1'b1; spi_rsp_slot = 4'd4; spi_rsp_data = 40'h77;
    #1 chk("late_rsp.pre", 64'(rsp_err), 64'd0); tick();
    spi_rsp_valid = 1'b0; req_slot = 4'd4;
    #1 chk("late_rsp.err", 64'(rsp_err), 64'd1);
    chk("late_rsp.slot_free", 64'(req_ready), 64'd1); tick();
    #1 chk("late_rsp.err_off", 64'(rsp_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
